// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a PC through a combinational instruction memory
// and feeds {PC, word} pairs to decode through a 2-entry FIFO, with redirect and halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstr,
  output logic [31:0] OutPC,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_q_pc  [2];
  logic [31:0] r_q_ins [2];
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [15:0] r_fcount;

  logic        w_redir;
  logic        w_valid;
  logic        w_full;
  logic        w_pop;
  logic        w_capture;
  logic        w_is_halt;
  logic        w_push;
  logic        w_wr_ptr;

  always_comb begin
    w_redir   = RedirectValid && (r_state != S_IDLE);
    w_valid   = (r_count != 2'd0);
    w_full    = (r_count == 2'd2);
    w_pop     = w_valid && OutReady && !w_redir;
    w_capture = (r_state == S_FETCH) && !w_redir && (!w_full || w_pop);
    w_is_halt = (Instruction == HALT_WORD);
    w_push    = w_capture && !w_is_halt;
    // When full and popping, the write slot is the one being vacated by the head.
    w_wr_ptr  = r_rd_ptr ^ r_count[0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_redir)                     w_state_nxt = S_FETCH;
        else if (w_capture && w_is_halt) w_state_nxt = S_HALT;
      end
      S_HALT:  if (w_redir) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc       <= RESET_PC & ~32'h3;
      r_q_pc[0]  <= '0;
      r_q_pc[1]  <= '0;
      r_q_ins[0] <= '0;
      r_q_ins[1] <= '0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
      r_fcount   <= '0;
    end else if (w_redir) begin
      r_pc     <= RedirectTarget & ~32'h3;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[w_wr_ptr]  <= r_pc;
        r_q_ins[w_wr_ptr] <= Instruction;
        r_pc              <= r_pc + 32'd4;
        if (r_fcount != 16'hFFFF) r_fcount <= r_fcount + 16'd1;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_comb begin
    PCResult   = r_pc;
    OutValid   = w_valid;
    OutInstr   = w_valid ? r_q_ins[r_rd_ptr] : '0;
    OutPC      = w_valid ? r_q_pc[r_rd_ptr]  : '0;
    Halted     = (r_state == S_HALT);
    FetchCount = r_fcount;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [31:0] PCResult;
  logic [31:0] Instruction;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;
  logic        Halted;
  logic [15:0] FetchCount;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(HALT)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .PCResult      (PCResult),
    .Instruction   (Instruction),
    .RedirectValid (RedirectValid),
    .RedirectTarget(RedirectTarget),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .OutInstr      (OutInstr),
    .OutPC         (OutPC),
    .Halted        (Halted),
    .FetchCount    (FetchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory image: word i holds i*3, except an optional word replaced by HALT.
  logic        halt_en;
  logic [31:0] halt_idx;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (halt_en && idx == halt_idx) return HALT;
    return idx * 32'd3;
  endfunction

  always_comb Instruction = mem_word(PCResult);

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: instruction queue, PC and mode, stepped on each edge.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  int          m_mode;  // 0 idle, 1 running, 2 halted
  logic [15:0] m_cnt;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_q.delete();
      m_pc   = 32'h0;
      m_mode = 0;
      m_cnt  = 16'h0;
    end else if (m_mode == 0) begin
      if (Start) m_mode = 1;
    end else if (RedirectValid) begin
      m_q.delete();
      m_pc   = RedirectTarget & ~32'h3;
      m_mode = 1;
    end else begin
      bit pop;
      bit cap;
      logic [31:0] w;
      pop = (m_q.size() > 0) && OutReady;
      cap = (m_mode == 1) && ((m_q.size() < 2) || pop);
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        w = mem_word(m_pc);
        if (w == HALT) m_mode = 2;
        else begin
          m_q.push_back('{pc: m_pc, ins: w});
          m_pc = m_pc + 32'd4;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en && Reset) begin
      check("m_valid", {31'b0, OutValid}, {31'b0, m_q.size() > 0});
      if (m_q.size() > 0) begin
        check("m_outpc", OutPC, m_q[0].pc);
        check("m_outinstr", OutInstr, m_q[0].ins);
      end
      check("m_pcresult", PCResult, m_pc);
      check("m_halted", {31'b0, Halted}, {31'b0, m_mode == 2});
      check("m_fetchcount", {16'b0, FetchCount}, {16'b0, m_cnt});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Start = 1'b0;
    RedirectValid = 1'b0;
    RedirectTarget = '0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    OutReady = 1'b1;
    RedirectValid = 1'b0;
    RedirectTarget = '0;
    halt_en = 1'b0;
    halt_idx = '0;

    // Reset state and streaming fetch with decode always ready.
    do_reset();
    check("rst_valid", {31'b0, OutValid}, 32'd0);
    check("rst_pc", PCResult, 32'h0);
    check("rst_outinstr", OutInstr, 32'h0);
    check("rst_outpc", OutPC, 32'h0);
    check("rst_halted", {31'b0, Halted}, 32'd0);
    check("rst_count", {16'b0, FetchCount}, 32'd0);
    chk_en = 1'b1;
    pulse_start();
    check("lat_valid0", {31'b0, OutValid}, 32'd0);
    tick();
    check("lat_valid1", {31'b0, OutValid}, 32'd1);
    check("s1_pc0", OutPC, 32'h0);
    check("s1_in0", OutInstr, 32'd0);
    tick();
    check("s1_pc1", OutPC, 32'h4);
    check("s1_in1", OutInstr, 32'd3);
    tick();
    check("s1_pc2", OutPC, 32'h8);
    check("s1_in2", OutInstr, 32'd6);
    tick();
    check("s1_pc3", OutPC, 32'hC);
    check("s1_in3", OutInstr, 32'd9);
    check("s1_count", {16'b0, FetchCount}, 32'd4);

    // Backpressure: FIFO fills with PC 0 and 4, then resumes without loss.
    do_reset();
    OutReady = 1'b0;
    pulse_start();
    repeat (5) tick();
    check("bp_pcresult", PCResult, 32'h8);
    check("bp_outpc", OutPC, 32'h0);
    check("bp_outinstr", OutInstr, 32'd0);
    check("bp_count", {16'b0, FetchCount}, 32'd2);
    OutReady = 1'b1;
    tick();
    check("bp_r1", OutInstr, 32'd3);
    tick();
    check("bp_r2", OutInstr, 32'd6);
    tick();
    check("bp_r3", OutInstr, 32'd9);

    // Redirect while full: flush, realign target.
    OutReady = 1'b0;
    repeat (3) tick();
    RedirectValid = 1'b1;
    RedirectTarget = 32'h0000_0042;
    tick();
    RedirectValid = 1'b0;
    check("rd_valid", {31'b0, OutValid}, 32'd0);
    check("rd_pc", PCResult, 32'h40);
    tick();
    check("rd_outpc", OutPC, 32'h40);
    check("rd_outinstr", OutInstr, 32'd48);
    OutReady = 1'b1;
    repeat (4) tick();

    // Halt word at index 3.
    do_reset();
    halt_en = 1'b1;
    halt_idx = 32'd3;
    pulse_start();
    repeat (3) tick();
    check("h_outpc8", OutPC, 32'h8);
    tick();
    check("h_halted", {31'b0, Halted}, 32'd1);
    check("h_pc", PCResult, 32'hC);
    check("h_count", {16'b0, FetchCount}, 32'd3);
    repeat (4) tick();
    check("h_pc_hold", PCResult, 32'hC);
    RedirectValid = 1'b1;
    RedirectTarget = 32'h0;
    tick();
    RedirectValid = 1'b0;
    check("h_resume_halted", {31'b0, Halted}, 32'd0);
    tick();
    check("h_resume_outpc", OutPC, 32'h0);
    repeat (6) tick();

    // Asynchronous reset mid-stream with two entries queued.
    do_reset();
    halt_en = 1'b0;
    OutReady = 1'b0;
    pulse_start();
    repeat (3) tick();
    check("ar_valid_pre", {31'b0, OutValid}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("ar_valid", {31'b0, OutValid}, 32'd0);
    check("ar_pc", PCResult, 32'h0);
    tick();
    Reset = 1'b1;
    OutReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ar_idle_pc", PCResult, 32'h0);
    end

    // Redirect on the same edge as a halt capture.
    do_reset();
    halt_en = 1'b1;
    halt_idx = 32'd2;
    pulse_start();
    tick();
    tick();
    check("rh_pc", PCResult, 32'h8);
    RedirectValid = 1'b1;
    RedirectTarget = 32'h100;
    tick();
    RedirectValid = 1'b0;
    check("rh_halted", {31'b0, Halted}, 32'd0);
    check("rh_pcresult", PCResult, 32'h100);
    tick();
    check("rh_outpc", OutPC, 32'h100);
    check("rh_outinstr", OutInstr, 32'd192);

    // FetchCount saturation.
    do_reset();
    halt_en = 1'b0;
    OutReady = 1'b1;
    pulse_start();
    repeat (65540) tick();
    check("sat_count", {16'b0, FetchCount}, 32'h0000_FFFF);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
